// File: rtl/serial_read_if.sv
// serial_read_if: bundle for the UART receiver.
//   rx         raw serial line into the receiver (idle high, asynchronous)
//   data       last good word
//   valid      word-held flag, level
//   ack        consumer strobe, only meaningful while valid=1
//   frame_err  one-cycle pulse on a low stop bit
//   overrun    sticky, an un-acked word was overwritten
//   RiP        reception in progress
// Handshake: a word is offered while valid=1 and stays stable until the
// consumer raises ack for at least one cycle; valid drops on the next edge.
// ack while valid=0 has no effect.
// modport master: the receiver.  modport slave: line driver / consumer.
interface serial_read_if #(
   parameter int DATA_BITS = 8
);
   logic                 rx;
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 ack;
   logic                 frame_err;
   logic                 overrun;
   logic                 RiP;

   modport master (
      input  rx,
      input  ack,
      output data,
      output valid,
      output frame_err,
      output overrun,
      output RiP
   );

   modport slave (
      output rx,
      output ack,
      input  data,
      input  valid,
      input  frame_err,
      input  overrun,
      input  RiP
   );
endinterface

// File: rtl/serial_read.sv
// serial_read: UART receiver for 1 start bit, DATA_BITS data bits (LSB
// first) and 1 stop bit, with a bit period of BAUD_DIVIDER clk cycles.
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   bus          serial_read_if.master (rx, ack in; data, valid,
//                frame_err, overrun, RiP out)
//   state_dbg_o  current receive state, for observation only
module serial_read #(
   parameter int BAUD_DIVIDER = 234,
   parameter int DATA_BITS    = 8
) (
   input  logic               clk,
   input  logic               rst,
   serial_read_if.master      bus,
   output logic [2:0]         state_dbg_o
);

   localparam int CNT_W = (BAUD_DIVIDER > 1) ? $clog2(BAUD_DIVIDER) : 1;
   localparam int IDX_W = $clog2(DATA_BITS + 1);
   localparam int HALF  = BAUD_DIVIDER / 2;

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIVIDER - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_BREAK = 3'd4;

   logic                 sync1_q, rx_s_q;
   logic [2:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ovr_q, ovr_d;
   logic                 fe_q, fe_d;
   logic                 load;
   logic                 ack_ok;

   // Two-flop synchroniser; reset to the idle level so reset never looks
   // like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
      end else begin
         sync1_q <= bus.rx;
         rx_s_q  <= sync1_q;
      end
   end

   // Receive state machine.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      sh_d    = sh_q;
      load    = 1'b0;
      fe_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rx_s_q) begin
               state_d = ST_START;
               cnt_d   = '0;
            end
         end
         ST_START: begin
            // Mid-start check: a low line is a real start, high is a glitch.
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (!rx_s_q) begin
                  state_d = ST_DATA;
                  idx_d   = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               // Shift right with the new bit entering at the MSB so the
               // first (LSB) bit ends up at bit 0 after DATA_BITS samples.
               sh_d = sh_q >> 1;
               sh_d[DATA_BITS-1] = rx_s_q;
               idx_d = idx_q + IDX_ONE;
               if (idx_q == IDX_LAST) begin
                  state_d = ST_STOP;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  load    = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  fe_d    = 1'b1;
                  state_d = ST_BREAK;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_BREAK: begin
            // A held-low line must return high before a new start is seen.
            if (rx_s_q) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output word and handshake.
   assign ack_ok = bus.ack & valid_q;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (load) begin
         data_d  = sh_q;
         valid_d = 1'b1;
         // An ack in the load cycle consumes the old word, so no overrun.
         if (valid_q && !bus.ack) begin
            ovr_d = 1'b1;
         end else if (ack_ok) begin
            ovr_d = 1'b0;
         end
      end else if (ack_ok) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         fe_q    <= fe_d;
      end
   end

   assign bus.data      = data_q;
   assign bus.valid     = valid_q;
   assign bus.overrun   = ovr_q;
   assign bus.frame_err = fe_q;
   assign bus.RiP       = (state_q != ST_IDLE);
   assign state_dbg_o   = state_q;

endmodule
